// File: rtl/demux1t8_32_buf.sv
// 1-to-8 write distributor: one write stream is routed by in_sel into eight
// single-entry holding buffers, each drained by its own valid/ready handshake.
module demux1t8_32_buf #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [2:0]         in_sel,
   input  logic [WIDTH-1:0]   in_data,
   output logic               in_ready,
   output logic [7:0]         out_valid,
   input  logic [7:0]         out_ready,
   output logic [8*WIDTH-1:0] out_data,
   output logic [CNT_W-1:0]   blocked_cnt
);

   logic [7:0] full_vec;
   logic       accept;
   logic       blocked;

   // A full buffer still accepts when its sink drains on the same edge.
   assign in_ready = ~full_vec[in_sel] | out_ready[in_sel];
   assign accept   = in_valid & in_ready;
   assign blocked  = in_valid & ~in_ready;

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_chan
         logic             full_reg;
         logic             full_next;
         logic [WIDTH-1:0] data_reg;
         logic             hit;

         assign hit = accept && (in_sel == 3'(gi));

         always_comb begin
            full_next = full_reg;
            if (full_reg && out_ready[gi])
               full_next = 1'b0;
            if (hit)
               full_next = 1'b1;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               full_reg <= 1'b0;
               data_reg <= '0;
            end else begin
               full_reg <= full_next;
               if (hit)
                  data_reg <= in_data;
            end
         end

         assign full_vec[gi]                  = full_reg;
         assign out_valid[gi]                 = full_reg;
         assign out_data[WIDTH*gi +: WIDTH]   = data_reg;
      end
   endgenerate

   // Saturating stall counter: holds at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         blocked_cnt <= '0;
      else if (blocked && (blocked_cnt != {CNT_W{1'b1}}))
         blocked_cnt <= blocked_cnt + 1'b1;
   end

endmodule

// File: tb/tb_demux1t8_32_buf.sv
// Bench for demux1t8_32_buf: directed vector table, hand-written corner
// sequences and a randomized run against a simple buffer-array model.
module tb_demux1t8_32_buf;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic [2:0]    in_sel;
   logic [31:0]   in_data;
   logic          in_ready;
   logic [7:0]    out_valid;
   logic [7:0]    out_ready;
   logic [255:0]  out_data;
   logic [15:0]   blocked_cnt;
   logic          in_ready_s;
   logic [7:0]    out_valid_s;
   logic [255:0]  out_data_s;
   logic [3:0]    blocked_cnt_s;

   int tests = 0;
   int fails = 0;

   // model state
   logic        m_full [8];
   logic [31:0] m_data [8];
   int          m_cnt;

   demux1t8_32_buf #(.WIDTH(32), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sel(in_sel),
      .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .blocked_cnt(blocked_cnt)
   );

   demux1t8_32_buf #(.WIDTH(32), .CNT_W(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sel(in_sel),
      .in_data(in_data), .in_ready(in_ready_s), .out_valid(out_valid_s),
      .out_ready(out_ready), .out_data(out_data_s), .blocked_cnt(blocked_cnt_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 8; k++) begin
         m_full[k] = 1'b0;
         m_data[k] = '0;
      end
      m_cnt = 0;
   endtask

   task automatic check_model(input string tag);
      logic [7:0]   ev;
      logic [255:0] ed;
      for (int k = 0; k < 8; k++) begin
         ev[k] = m_full[k];
         ed[32*k +: 32] = m_data[k];
      end
      check({tag, ".out_valid"}, 256'(out_valid), 256'(ev));
      check({tag, ".out_data"}, out_data, ed);
      check({tag, ".blocked_cnt"}, 256'(blocked_cnt), 256'((m_cnt > 65535) ? 65535 : m_cnt));
      check({tag, ".blocked_cnt4"}, 256'(blocked_cnt_s), 256'((m_cnt > 15) ? 15 : m_cnt));
   endtask

   // One clock of stimulus; outputs and in_ready are checked at the negedge.
   task automatic cycle(input logic v, input logic [2:0] s, input logic [31:0] d,
                        input logic [7:0] r, output logic rdy_seen);
      logic exp_rdy;
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      out_ready = r;
      @(negedge clk);
      rdy_seen = in_ready;
      exp_rdy = !m_full[s] || r[s];
      check_model("pre");
      check("in_ready", 256'(in_ready), 256'(exp_rdy));
      if (v && !exp_rdy) m_cnt++;
      for (int k = 0; k < 8; k++)
         if (m_full[k] && r[k]) m_full[k] = 1'b0;
      if (v && exp_rdy) begin
         m_full[s] = 1'b1;
         m_data[s] = d;
      end
      @(posedge clk);
      #1;
      $display("[TB] t=%0t v=%0b sel=%0d data=%h ordy=%h rdy=%0b -> ov=%h cnt=%0d",
               $time, v, s, d, r, rdy_seen, out_valid, blocked_cnt);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sel    = '0;
      in_data   = '0;
      out_ready = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        v;
      logic [2:0]  sel;
      logic [31:0] data;
      logic [7:0]  ordy;
      logic        exp_rdy;
      logic [7:0]  exp_ov;
   } vec_t;

   vec_t tbl [7];
   logic rdy;

   initial begin
      tbl[0] = '{1'b1, 3'd3, 32'hDEADBEEF, 8'h00, 1'b1, 8'h08};
      tbl[1] = '{1'b0, 3'd3, 32'h00000000, 8'h00, 1'b0, 8'h08};
      tbl[2] = '{1'b1, 3'd0, 32'h00000001, 8'hFF, 1'b1, 8'h01};
      tbl[3] = '{1'b1, 3'd0, 32'h00000002, 8'hFF, 1'b1, 8'h01};
      tbl[4] = '{1'b1, 3'd0, 32'h00000003, 8'hFF, 1'b1, 8'h01};
      tbl[5] = '{1'b1, 3'd0, 32'h00000004, 8'hFF, 1'b1, 8'h01};
      tbl[6] = '{1'b0, 3'd0, 32'h00000000, 8'hFF, 1'b1, 8'h00};

      do_reset();
      check("reset.out_valid", 256'(out_valid), 256'h0);
      check("reset.out_data", out_data, 256'h0);
      check("reset.blocked_cnt", 256'(blocked_cnt), 256'h0);

      // single write and streaming
      for (int i = 0; i < 7; i++) begin
         cycle(tbl[i].v, tbl[i].sel, tbl[i].data, tbl[i].ordy, rdy);
         check($sformatf("tbl%0d.in_ready", i), 256'(rdy), 256'(tbl[i].exp_rdy));
         check($sformatf("tbl%0d.out_valid", i), 256'(out_valid), 256'(tbl[i].exp_ov));
         if (i == 0)
            check("tbl0.ch3", 256'(out_data[96 +: 32]), 256'h0DEADBEEF);
         if (i >= 2 && i <= 5)
            check($sformatf("tbl%0d.ch0", i), 256'(out_data[31:0]), 256'(i - 1));
      end

      // stall and count on channel 5
      do_reset();
      cycle(1'b1, 3'd5, 32'h55555555, 8'h00, rdy);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 3'd5, 32'h1000 + 32'(i), 8'h00, rdy);
         check("stall.in_ready", 256'(rdy), 256'h0);
      end
      check("stall.blocked_cnt", 256'(blocked_cnt), 256'd10);
      check("stall.ch5", 256'(out_data[160 +: 32]), 256'h55555555);
      cycle(1'b1, 3'd5, 32'h77777777, 8'h20, rdy);
      check("stall.release_rdy", 256'(rdy), 256'h1);
      check("stall.release_ov", 256'(out_valid), 256'h20);
      check("stall.release_ch5", 256'(out_data[160 +: 32]), 256'h77777777);

      // channel isolation
      do_reset();
      cycle(1'b1, 3'd2, 32'h22222222, 8'h00, rdy);
      cycle(1'b1, 3'd2, 32'h33333333, 8'h00, rdy);
      check("iso.blocked", 256'(rdy), 256'h0);
      cycle(1'b1, 3'd6, 32'hA5A5A5A5, 8'h00, rdy);
      check("iso.rdy6", 256'(rdy), 256'h1);
      check("iso.out_valid", 256'(out_valid), 256'h44);

      // simultaneous drain of 0,1,7
      do_reset();
      cycle(1'b1, 3'd0, 32'hC0C0C0C0, 8'h00, rdy);
      cycle(1'b1, 3'd1, 32'hC1C1C1C1, 8'h00, rdy);
      cycle(1'b1, 3'd7, 32'hC7C7C7C7, 8'h00, rdy);
      check("drain.pre_ov", 256'(out_valid), 256'h83);
      cycle(1'b0, 3'd4, 32'h0, 8'h83, rdy);
      check("drain.ov", 256'(out_valid), 256'h00);
      check("drain.ch7", 256'(out_data[224 +: 32]), 256'hC7C7C7C7);
      check("drain.ch1", 256'(out_data[32 +: 32]), 256'hC1C1C1C1);

      // async reset mid-operation
      for (int k = 0; k < 8; k++)
         cycle(1'b1, 3'(k), 32'hF0000000 | 32'(k), 8'h00, rdy);
      for (int i = 0; i < 7; i++)
         cycle(1'b1, 3'(i), 32'h0, 8'h00, rdy);
      check("arst.pre_ov", 256'(out_valid), 256'hFF);
      check("arst.pre_cnt", 256'(blocked_cnt), 256'd7);
      in_valid = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      check("arst.ov", 256'(out_valid), 256'h0);
      check("arst.data", out_data, 256'h0);
      check("arst.cnt", 256'(blocked_cnt), 256'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cycle(1'b1, 3'd3, 32'hDEADBEEF, 8'h00, rdy);
      check("arst.after_ov", 256'(out_valid), 256'h08);
      check("arst.after_ch3", 256'(out_data[96 +: 32]), 256'hDEADBEEF);

      // saturation of the 4-bit counter instance
      do_reset();
      cycle(1'b1, 3'd4, 32'h44444444, 8'h00, rdy);
      for (int i = 0; i < 20; i++)
         cycle(1'b1, 3'd4, 32'h0, 8'h00, rdy);
      check("sat.cnt4", 256'(blocked_cnt_s), 256'd15);
      check("sat.cnt16", 256'(blocked_cnt), 256'd20);

      // randomized run against the model
      do_reset();
      for (int i = 0; i < 300; i++) begin
         cycle(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), $urandom(),
               8'($urandom() & $urandom()), rdy);
      end
      check_model("final");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/demux1t8_32_buf.md
Name: demux1t8_32_buf

Overview:
- 1-to-8 write distributor, the inverse of the 8-to-1 32-bit read selector.
- Accepts a single 32-bit write stream tagged with a 3-bit destination select.
- Routes each write into one of eight one-entry holding buffers, each with its own valid/ready output handshake.
- Sits between the CPU/bus write path and up to eight peripheral sinks (display, LEDs, timers, …), decoupling a stalled sink from the others.

Parameters:
- WIDTH, 32, data width of input and of each output channel.
- CNT_W, 16, width of the saturating blocked-cycle counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  write request present.
- in_sel  input  3  destination channel, 0..7.
- in_data  input  WIDTH  write data.
- in_ready  output  1  write accepted this cycle when high together with in_valid.
- out_valid  output  8  bit k: channel k buffer holds undelivered data.
- out_ready  input  8  bit k: sink k takes data this cycle.
- out_data  output  8*WIDTH  packed channel data; channel k occupies bits [WIDTH*k+WIDTH-1 : WIDTH*k].
- blocked_cnt  output  CNT_W  saturating count of cycles with in_valid=1 and in_ready=0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all eight full flags = 0, so out_valid = 8'h00;
  - all data registers = 0, so out_data = 0;
  - blocked_cnt = 0.
  - Reset asserted mid-transfer discards all buffered data; no partial state survives.
- Per channel k: one data register data_k and one flag full_k. out_valid[k] = full_k; out_data channel k = data_k (registered, no combinational path from in_data).
- in_ready is combinational: in_ready = !full[in_sel] | out_ready[in_sel].
  - Depends only on the selected channel; other channels' state never stalls the input.
  - in_ready is meaningful whether or not in_valid is high.
- Accept: in_valid & in_ready at a rising edge.
  - data_{in_sel} <= in_data; full_{in_sel} <= 1.
  - Latency: data visible on out_data and out_valid one cycle after acceptance.
- Drain: out_valid[k] & out_ready[k] at a rising edge.
  - full_k <= 0, unless the same edge also accepts a write to k. In that case full_k stays 1 and data_k takes the new value: back-to-back throughput of one write per cycle per channel.
- out_ready[k] while out_valid[k]=0 has no effect.
- Drains on several channels in one cycle are independent and all take effect.
- Stability: while out_valid[k]=1 and out_ready[k]=0, data_k is held unchanged; the input is stalled by in_ready=0 if it targets k.
- After a drain, data_k retains its last value (not cleared); only out_valid drops.
- blocked_cnt: increments by 1 on each edge where in_valid=1 and in_ready=0. Saturates at 2^CNT_W-1 and holds; no wrap.
- in_sel and in_data may change freely while in_valid=0 and are ignored.
- Input-side protocol: no requirement that the source hold a stalled request; the block is purely ready-based.
- No X propagation: every out_valid/out_data bit is driven from registers in all states.

Test Plan:
- Reset then single write: in_sel=3, in_data=32'hDEADBEEF, out_ready=0.
  - Cycle+1: out_valid=8'h08, channel 3 = DEADBEEF, in_ready for sel 3 = 0.
  - Other channels remain 0.
- Stall and count: channel 5 full, out_ready[5]=0, hold in_valid with sel=5 for 10 cycles.
  - in_ready=0 throughout; blocked_cnt=10; channel 5 data unchanged.
  - Then raise out_ready[5]: write accepted that edge; out_valid[5] stays 1 with the new data.
- Streaming: out_ready=8'hFF, write 0x1,0x2,0x3,0x4 to sel=0 on consecutive cycles.
  - in_ready=1 every cycle; channel 0 shows 1,2,3,4 on successive cycles.
  - out_valid[0] drops the cycle after the last write.
- Channel isolation: channel 2 full and blocked; write 32'hA5A5A5A5 to sel=6.
  - Accepted immediately; out_valid=8'h44.
- Simultaneous drain on multiple channels: channels 0,1,7 full, out_ready=8'h83.
  - Next cycle out_valid=8'h00; data registers retain their values.
- Async reset mid-operation: assert rst_n low between clock edges with out_valid=8'hFF and blocked_cnt=7.
  - Outputs go to 0 immediately, without waiting for clk.
  - After release, the first write behaves as in scenario 1.
- Saturation (CNT_W=4): block for 20 cycles → blocked_cnt=15, held.
